// File: rtl/mmcm_drp_pkg.sv
// rtl/mmcm_drp_pkg.sv - shared types and constants for the MMCM DRP reconfiguration controller
//
// Contents:
//   state_t            controller FSM states
//   *_REG1 / DIVCLK /  MMCM DRP register addresses used by reconfiguration sessions
//   POWER
//   DEF_*_TIMEOUT      default timeout limits in clk cycles
//   drp_merge()        read-modify-write field merge

package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FETCH,
        RELEASE,
        LOCK_WAIT,
        ERR
    } state_t;

    localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] CLKOUT1_REG1  = 7'h0A;
    localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] DIVCLK        = 7'h16;
    localparam logic [6:0] POWER         = 7'h28;

    localparam int DEF_DRDY_TIMEOUT = 64;
    localparam int DEF_LOCK_TIMEOUT = 65535;

    // Bits set in mask take the new value; the rest keep what was read back.
    function automatic logic [15:0] drp_merge(input logic [15:0] rd,
                                              input logic [15:0] mask,
                                              input logic [15:0] data);
        return (rd & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_if.sv
// rtl/mmcm_drp_ctrl_if.sv - configuration entry handshake plus DRP request/response bus
//
// Signals:
//   cfg_valid/cfg_ready       entry handshake (transfer when both high)
//   cfg_addr/mask/data/last   entry payload
//   daddr/den/dwe/di          DRP request towards the MMCM
//   dout/drdy                 DRP response from the MMCM
// Modports:
//   master  entry source and DRP port owner (MMCM side / bench)
//   slave   the controller

interface mmcm_drp_ctrl_if;

    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic        cfg_last;

    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;

    modport master (
        output cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last,
        input  cfg_ready,
        input  daddr, den, dwe, di,
        output dout, drdy
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last,
        output cfg_ready,
        output daddr, den, dwe, di,
        input  dout, drdy
    );

endinterface

// File: rtl/mmcm_drp_ctrl.sv
// rtl/mmcm_drp_ctrl.sv - MMCM dynamic reconfiguration controller (read-modify-write sessions over DRP)
//
// Ports:
//   clk       DRP clock, also the MMCM DCLK
//   rst       asynchronous active-high reset
//   bus       mmcm_drp_ctrl_if.slave: entry handshake and DRP port
//   mmcm_rst  MMCM RST, high for the whole session until release
//   locked    MMCM LOCKED (asynchronous, synchronised here)
//   busy      session active
//   done      one-cycle pulse on successful lock
//   error     sticky failure flag, cleared by the next session start
//   wr_count  entries written in the current or last session (saturating)

module mmcm_drp_ctrl
    import mmcm_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    mmcm_drp_ctrl_if.slave        bus,
    output logic                  mmcm_rst,
    input  logic                  locked,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            wr_count
);

    // The timer counts cycles spent in a wait state starting from 0, so a
    // limit of N means the Nth waiting cycle without a response errors out.
    localparam logic [15:0] DRDY_LIMIT = 16'(DRDY_TIMEOUT - 1);
    localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT - 1);

    state_t      state;
    logic        cfg_ready_q;
    logic [6:0]  daddr_q;
    logic        den_q;
    logic        dwe_q;
    logic [15:0] di_q;
    logic        mmcm_rst_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [7:0]  wr_count_q;
    logic [15:0] timer;

    logic [6:0]  addr_q;
    logic [15:0] mask_q;
    logic [15:0] data_q;
    logic        last_q;
    logic [15:0] rd_q;

    logic [1:0]  lock_sync;
    logic        locked_s;
    logic        accept;

    assign accept   = bus.cfg_valid && cfg_ready_q;
    assign locked_s = lock_sync[1];

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.daddr     = daddr_q;
    assign bus.den       = den_q;
    assign bus.dwe       = dwe_q;
    assign bus.di        = di_q;
    assign mmcm_rst      = mmcm_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign wr_count      = wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], locked};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cfg_ready_q <= 1'b0;
            daddr_q     <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            di_q        <= '0;
            mmcm_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wr_count_q  <= '0;
            timer       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            rd_q        <= '0;
        end else begin
            // den/dwe are single-cycle strobes and done is a pulse; they are
            // re-armed only on the transitions that need them.
            den_q  <= 1'b0;
            dwe_q  <= 1'b0;
            done_q <= 1'b0;
            timer  <= timer + 16'd1;

            case (state)
                IDLE, FETCH: begin
                    cfg_ready_q <= 1'b1;
                    if (accept) begin
                        addr_q      <= bus.cfg_addr;
                        mask_q      <= bus.cfg_mask;
                        data_q      <= bus.cfg_data;
                        last_q      <= bus.cfg_last;
                        daddr_q     <= bus.cfg_addr;
                        den_q       <= 1'b1;
                        cfg_ready_q <= 1'b0;
                        state       <= RD_REQ;
                        if (state == IDLE) begin
                            error_q    <= 1'b0;
                            wr_count_q <= '0;
                            busy_q     <= 1'b1;
                            mmcm_rst_q <= 1'b1;
                        end
                    end
                end

                RD_REQ: begin
                    timer <= '0;
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    // A response in the final allowed cycle beats the timeout.
                    if (bus.drdy) begin
                        rd_q    <= bus.dout;
                        daddr_q <= addr_q;
                        di_q    <= drp_merge(bus.dout, mask_q, data_q);
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state   <= WR_REQ;
                    end else if (timer == DRDY_LIMIT) begin
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        state      <= ERR;
                    end
                end

                WR_REQ: begin
                    timer <= '0;
                    state <= WR_WAIT;
                end

                WR_WAIT: begin
                    if (bus.drdy) begin
                        if (wr_count_q != 8'hFF) begin
                            wr_count_q <= wr_count_q + 8'd1;
                        end
                        if (last_q) begin
                            state <= RELEASE;
                        end else begin
                            cfg_ready_q <= 1'b1;
                            state       <= FETCH;
                        end
                    end else if (timer == DRDY_LIMIT) begin
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        state      <= ERR;
                    end
                end

                RELEASE: begin
                    // The lock timeout is measured from the cycle RST actually drops.
                    mmcm_rst_q <= 1'b0;
                    timer      <= '0;
                    state      <= LOCK_WAIT;
                end

                LOCK_WAIT: begin
                    if (locked_s) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else if (timer == LOCK_LIMIT) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ERR;
                    end
                end

                ERR: begin
                    cfg_ready_q <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
